// File: rtl/core_pkg.sv
// Shared register-file writeback types and helpers.
//   rf_write_req_t : {addr, data, en} request to a register-file write port
//   rf_write_rsp_t : {done} completion returned to the requester
//   rf_arb_state_e : write-port arbiter FSM states
//   RF_WB_PORTS    : default number of writeback requesters
//   wrap_inc       : modulo increment used for round-robin pointers
package core;

    localparam int RF_ADDR_W   = 5;
    localparam int RF_DATA_W   = 32;
    localparam int RF_WB_PORTS = 2;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
        logic                 en;
    } rf_write_req_t;

    typedef struct packed {
        logic done;
    } rf_write_rsp_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } rf_arb_state_e;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rf_write_arbiter_rr_picker.sv
// Combinational round-robin picker: returns the first set bit of req_vec at
// or after ptr, wrapping cyclically.
//   req_vec : in  NUM_REQ  request bits
//   ptr     : in  IDX_W    search start position
//   found   : out 1        any request bit set
//   idx     : out IDX_W    selected index (0 when none found)
module rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_vec,
    input  logic [IDX_W-1:0]   ptr,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        found = |req_vec;
        idx   = '0;
        cand  = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            cand = IDX_W'((int'(ptr) + off) % NUM_REQ);
            if (req_vec[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares one register-file write port among NUM_REQ writeback requesters.
// Round-robin arbitration with a registered grant held until the port
// reports done; x0 writes are retired locally without arbitration.
//   clk       : in  clock
//   rst       : in  asynchronous active-low reset
//   req       : in  per-requester write requests
//   rsp       : out per-requester done
//   rf_req    : out request to the register-file write port
//   rf_rsp    : in  response from the register-file write port
//   grant_vec : out one-hot owner, 0 when idle
//   busy      : out high while a grant is held
//
// state | meaning
// IDLE  | no owner; arbitrate among candidates, register the winner
// GRANT | owner gnt_idx drives the port until done or it drops en
module rf_write_arbiter
    import core::*;
#(
    parameter int NUM_REQ = RF_WB_PORTS,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  rf_write_req_t [NUM_REQ-1:0]   req,
    output rf_write_rsp_t [NUM_REQ-1:0]   rsp,
    output rf_write_req_t                 rf_req,
    input  rf_write_rsp_t                 rf_rsp,
    output logic [NUM_REQ-1:0]            grant_vec,
    output logic                          busy
);

    rf_arb_state_e      state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;

    logic [NUM_REQ-1:0] cand_vec;
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   ptr_after_gnt;
    rf_write_req_t      owner_req;

    // x0 writes are never candidates; they retire on the local path.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_vec[i] = req[i].en && (req[i].addr != '0);
        end
    end

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req_vec (cand_vec),
        .ptr     (ptr_q),
        .found   (pick_found),
        .idx     (pick_idx)
    );

    assign owner_req     = req[gnt_idx_q];
    assign ptr_after_gnt = IDX_W'(wrap_inc(int'(gnt_idx_q), NUM_REQ));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            gnt_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_idx_q <= gnt_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_idx_d = gnt_idx_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d   = GRANT;
                    gnt_idx_d = pick_idx;
                end
            end
            GRANT: begin
                // An owner that drops en releases the port just like done.
                if (!owner_req.en || rf_rsp.done) begin
                    state_d = IDLE;
                    ptr_d   = ptr_after_gnt;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rf_req    = '0;
        grant_vec = '0;
        busy      = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp[i].done = rst && req[i].en && (req[i].addr == '0);
        end
        if (state_q == GRANT) begin
            rf_req    = owner_req;
            rf_req.en = owner_req.en && rst;
            grant_vec = NUM_REQ'(1) << gnt_idx_q;
            busy      = 1'b1;
            if (owner_req.en && rf_rsp.done && rst) begin
                rsp[gnt_idx_q].done = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;
    import core::*;

    logic                    clk;
    logic                    rst;
    rf_write_req_t [1:0]     req;
    rf_write_rsp_t [1:0]     rsp;
    rf_write_req_t           rf_req;
    rf_write_rsp_t           rf_rsp;
    logic [1:0]              grant_vec;
    logic                    busy;

    int n_checks = 0;
    int n_errors = 0;

    rf_write_arbiter #(.NUM_REQ(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .rsp       (rsp),
        .rf_req    (rf_req),
        .rf_rsp    (rf_rsp),
        .grant_vec (grant_vec),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst_v;
        logic        en0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        en1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        done;
        logic        e_en;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic [1:0]  e_done;
        logic [1:0]  e_gnt;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    function automatic vec_t mk(input string name, input logic r,
                                input logic en0, input logic [4:0] a0, input logic [31:0] d0,
                                input logic en1, input logic [4:0] a1, input logic [31:0] d1,
                                input logic done, input logic e_en, input logic [4:0] e_addr,
                                input logic [31:0] e_data, input logic [1:0] e_done,
                                input logic [1:0] e_gnt, input logic e_busy);
        vec_t v;
        v.name = name; v.rst_v = r;
        v.en0 = en0; v.a0 = a0; v.d0 = d0;
        v.en1 = en1; v.a1 = a1; v.d1 = d1;
        v.done = done;
        v.e_en = e_en; v.e_addr = e_addr; v.e_data = e_data;
        v.e_done = e_done; v.e_gnt = e_gnt; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        rst          = v.rst_v;
        req[0].en    = v.en0;
        req[0].addr  = v.a0;
        req[0].data  = v.d0;
        req[1].en    = v.en1;
        req[1].addr  = v.a1;
        req[1].data  = v.d1;
        rf_rsp.done  = v.done;
        sb.push_back(v);
    endtask

    task automatic cmp(input string name, input string field,
                       input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s %s got %h want %h", name, field, got, want);
        end
    endtask

    task automatic check_out();
        vec_t v;
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_empty got 0 want 1");
            return;
        end
        v = sb.pop_front();
        cmp(v.name, "rf_en",   32'(rf_req.en),   32'(v.e_en));
        cmp(v.name, "rf_addr", 32'(rf_req.addr), 32'(v.e_addr));
        cmp(v.name, "rf_data", rf_req.data,      v.e_data);
        cmp(v.name, "done",    32'({rsp[1].done, rsp[0].done}), 32'(v.e_done));
        cmp(v.name, "grant",   32'(grant_vec),   32'(v.e_gnt));
        cmp(v.name, "busy",    32'(busy),        32'(v.e_busy));
    endtask

    localparam logic [31:0] DA = 32'h0000_00A0;
    localparam logic [31:0] DB = 32'h0000_00B1;
    localparam logic [31:0] DE = 32'hDEAD_BEEF;

    initial begin
        // name            rst en0 a0 d0       en1 a1 d1  done | en addr data done gnt busy
        vecs.push_back(mk("rst_low",     0, 1, 5, 32'h11, 1, 0, 0,  0,  0, 0, 0,    2'b00, 2'b00, 0));
        vecs.push_back(mk("rst_rel_x0",  1, 1, 5, 32'h11, 1, 0, 0,  0,  0, 0, 0,    2'b10, 2'b00, 0));
        vecs.push_back(mk("first_gnt",   1, 1, 5, 32'h11, 0, 0, 0,  0,  1, 5, 32'h11, 2'b00, 2'b01, 1));
        vecs.push_back(mk("first_done",  1, 1, 5, 32'h11, 0, 0, 0,  1,  1, 5, 32'h11, 2'b01, 2'b01, 1));
        vecs.push_back(mk("sw_idle",     1, 0, 5, 32'h11, 1, 7, DE, 1,  0, 0, 0,    2'b00, 2'b00, 0));
        vecs.push_back(mk("sw_write",    1, 0, 5, 32'h11, 1, 7, DE, 1,  1, 7, DE,   2'b10, 2'b10, 1));
        vecs.push_back(mk("sw_after",    1, 0, 0, 0,      0, 7, DE, 1,  0, 0, 0,    2'b00, 2'b00, 0));
        vecs.push_back(mk("rr_idle0",    1, 1, 3, DA,     1, 4, DB, 1,  0, 0, 0,    2'b00, 2'b00, 0));
        vecs.push_back(mk("rr_g0a",      1, 1, 3, DA,     1, 4, DB, 1,  1, 3, DA,   2'b01, 2'b01, 1));
        vecs.push_back(mk("rr_idle1",    1, 1, 3, DA,     1, 4, DB, 1,  0, 0, 0,    2'b00, 2'b00, 0));
        vecs.push_back(mk("rr_g1a",      1, 1, 3, DA,     1, 4, DB, 1,  1, 4, DB,   2'b10, 2'b10, 1));
        vecs.push_back(mk("rr_idle2",    1, 1, 3, DA,     1, 4, DB, 1,  0, 0, 0,    2'b00, 2'b00, 0));
        vecs.push_back(mk("rr_g0b",      1, 1, 3, DA,     1, 4, DB, 1,  1, 3, DA,   2'b01, 2'b01, 1));
        vecs.push_back(mk("rr_idle3",    1, 1, 3, DA,     1, 4, DB, 1,  0, 0, 0,    2'b00, 2'b00, 0));
        vecs.push_back(mk("rr_g1b",      1, 1, 3, DA,     1, 4, DB, 1,  1, 4, DB,   2'b10, 2'b10, 1));
        vecs.push_back(mk("stall_idle",  1, 1, 3, DA,     1, 4, DB, 0,  0, 0, 0,    2'b00, 2'b00, 0));
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk($sformatf("stall_%0d", k), 1, 1, 3, DA, 1, 4, DB, 0, 1, 3, DA, 2'b00, 2'b01, 1));
        vecs.push_back(mk("x0_retire",   1, 1, 3, DA,     1, 0, DB, 0,  1, 3, DA,   2'b10, 2'b01, 1));
        vecs.push_back(mk("abort",       1, 0, 3, DA,     0, 4, DB, 1,  0, 3, DA,   2'b00, 2'b01, 1));
        vecs.push_back(mk("abort_idle",  1, 1, 3, DA,     1, 4, DB, 1,  0, 0, 0,    2'b00, 2'b00, 0));
        vecs.push_back(mk("abort_ptr1",  1, 1, 3, DA,     1, 4, DB, 1,  1, 4, DB,   2'b10, 2'b10, 1));
        vecs.push_back(mk("pre_rst_idl", 1, 1, 3, DA,     0, 4, DB, 0,  0, 0, 0,    2'b00, 2'b00, 0));
        vecs.push_back(mk("pre_rst_gnt", 1, 1, 3, DA,     0, 4, DB, 0,  1, 3, DA,   2'b00, 2'b01, 1));

        rst = 1'b0;
        req = '0;
        rf_rsp = '0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            apply(vecs[i]);
            #3;
            check_out();
            @(posedge clk); #1;
        end

        // Async reset pulled between edges while owner 0 holds the grant.
        apply(mk("hold_gnt",    1, 1, 3, DA, 0, 4, DB, 0, 1, 3, DA, 2'b00, 2'b01, 1));
        #1;
        check_out();
        #1;
        apply(mk("async_rst",   0, 1, 3, DA, 0, 4, DB, 0, 0, 0, 0,  2'b00, 2'b00, 0));
        #1;
        check_out();
        @(posedge clk); #1;
        apply(mk("rst_release", 1, 1, 3, DA, 1, 4, DB, 0, 0, 0, 0,  2'b00, 2'b00, 0));
        #3;
        check_out();
        @(posedge clk); #1;
        apply(mk("rearb",       1, 1, 3, DA, 1, 4, DB, 1, 1, 3, DA, 2'b01, 2'b01, 1));
        #3;
        check_out();
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
Shares the single register-file write port between NUM_REQ writeback requesters, e.g. the writeback stages of parallel branch paths. Each requester presents a core::rf_write_req_t and waits for core::rf_write_rsp_t.done. The arbiter picks one requester round-robin, locks the grant until the downstream port reports done, and routes done back to the owner only. Writes to x0 are retired locally and never forwarded.

Parameters:
NUM_REQ, 2, number of writeback requesters (>=1)
IDX_W, $clog2(NUM_REQ) (min 1), width of grant index / round-robin pointer

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-low reset
req  in  NUM_REQ x core::rf_write_req_t  per-requester write request {addr, data, en}
rsp  out  NUM_REQ x core::rf_write_rsp_t  per-requester response {done}
rf_req  out  core::rf_write_req_t  request to register-file write port
rf_rsp  in  core::rf_write_rsp_t  response from register-file write port
grant_vec  out  NUM_REQ  one-hot current owner, 0 when idle
busy  out  1  high while in state GRANT

Behaviour:
- Reset: rst low asynchronously forces state=IDLE, ptr=0, gnt_idx=0. While rst is low: rf_req.en=0, all rsp[i].done=0, grant_vec=0, busy=0.
- Candidate i: req[i].en && req[i].addr != 0.
- x0 retire: req[i].en && addr==0 gives rsp[i].done=1 combinationally in the same cycle, in any state, never arbitrated. Blocked while rst is low.
- FSM states: IDLE, GRANT.
- IDLE, no candidate: stay in IDLE, rf_req.en=0.
- IDLE, any candidate: rr_picker selects the first candidate at or after ptr, cyclically. Register gnt_idx and go to GRANT next cycle. No downstream write happens in this cycle; this is the registered arbitration bubble.
- GRANT outputs:
  - rf_req.addr/data come from req[gnt_idx].
  - rf_req.en = req[gnt_idx].en && rst.
  - grant_vec = 1<<gnt_idx, busy=1.
- GRANT, rf_rsp.done=1 and req[gnt_idx].en=1:
  - rsp[gnt_idx].done=1 in the same cycle (combinational pass-through).
  - Next cycle: state=IDLE, ptr=(gnt_idx+1) mod NUM_REQ.
- GRANT, req[gnt_idx].en=0 (owner flushed or aborted):
  - rf_req.en=0 that cycle; rf_rsp.done is ignored.
  - Next cycle: state=IDLE, ptr=(gnt_idx+1) mod NUM_REQ.
- GRANT, rf_rsp.done=0: hold the grant. Stall length is unbounded and set by the port.
- Requester contract: hold addr/data stable while en=1 until done is seen. The arbiter does not latch data.
- Non-owners never see done, except through the x0 path. rf_rsp.done outside GRANT is ignored.
- Latency: minimum 2 cycles from req.en to done (1 arbitration + 1 write). Back-to-back grants are separated by 1 IDLE cycle.
- Fairness: a continuously requesting port waits at most NUM_REQ-1 grants.
- ptr wraps from NUM_REQ-1 to 0. With NUM_REQ=1, ptr stays 0.
- rst deasserting mid-operation: the FSM restarts from IDLE. Any in-flight write is dropped, and the requester re-arbitrates.

Decomposition:
- Package core holds the existing rf_write_req_t / rf_write_rsp_t.
- Add to core:
  - rf_arb_state_e {IDLE, GRANT}
  - localparam RF_WB_PORTS (default requester count)
- Sub-module rr_picker: purely combinational. Inputs: NUM_REQ request vector and ptr. Outputs: found flag and index. Reusable by other shared-resource arbiters.
- rf_write_arbiter owns the FSM, ptr, gnt_idx, output muxing and response demux.

Test Plan:
- Reset: drive rst=0 with req[0].en=1, addr=5 -> rf_req.en=0, rsp=0, busy=0; release rst, next cycle grant_vec=01.
- Single write: req[1]={addr 7, data 0xDEADBEEF, en 1}, rf_rsp.done=1 from cycle 2 -> cycle 1 IDLE, cycle 2 rf_req={7, 0xDEADBEEF, 1} and rsp[1].done=1, cycle 3 busy=0.
- Contention and round-robin: req[0] and req[1] held active with addrs 3/4 and done always 1 -> grants alternate 0,1,0,1. Each done arrives on its owner's port only; ptr toggles.
- Stall: owner 0 granted, rf_rsp.done low for 5 cycles -> grant_vec=01 and rf_req stable for all 5 cycles, req[1] not granted, rsp[1].done=0 throughout.
- x0 and abort:
  - req[1]={addr 0, en 1} while 0 owns the grant -> rsp[1].done=1 the same cycle, rf_req still shows requester 0.
  - Owner 0 drops en mid-GRANT -> rf_req.en=0, next cycle IDLE, ptr=1.
- Async reset mid-GRANT: pull rst low between clock edges -> rf_req.en falls immediately, and state=IDLE on release.
